lut_sweep_engine: RTL and testbench

LUT_SWEEP_ENGINE -- requirements
Module: lut_sweep_engine

---
 rtl/lut_sweep_pkg.sv | 14 +
 rtl/lut_sweep_table.sv | 53 +++++
 rtl/lut_sweep_engine.sv | 115 +++++++++++
 tb/tb_lut_sweep_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_sweep_pkg.sv
// Shared types and default sizing for the LUT sweep engine.
package lut_sweep_pkg;

    localparam int unsigned DefNIn   = 4;
    localparam int unsigned DefNFunc = 10;

    // Controller state: idle, single-row evaluation, or full-table sweep.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StEval  = 2'd1,
        StSweep = 2'd2
    } state_e;

endpackage

// File: rtl/lut_sweep_table.sv
// Truth-table storage: one 2**N_IN-bit column per function, written a whole
// column at a time, read as one bit per function at a single row.
module lut_sweep_table
    import lut_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = DefNIn,
    parameter int unsigned N_FUNC = DefNFunc,
    localparam int unsigned FuncW = (N_FUNC > 1) ? $clog2(N_FUNC) : 1,
    localparam int unsigned Rows  = 2 ** N_IN
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [FuncW-1:0]  wr_func_i,
    input  logic [Rows-1:0]   wr_data_i,
    input  logic [N_IN-1:0]   rd_row_i,
    output logic [N_FUNC-1:0] rd_f_o
);

    logic [Rows-1:0] mem_q [N_FUNC];
    logic [Rows-1:0] mem_d [N_FUNC];

    // Column write; an index with no matching function simply writes nothing.
    always_comb begin
        for (int j = 0; j < int'(N_FUNC); j++) begin
            mem_d[j] = mem_q[j];
            if (wr_en_i && (wr_func_i == FuncW'(j))) begin
                mem_d[j] = wr_data_i;
            end
        end
    end

    // Storage flops, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int j = 0; j < int'(N_FUNC); j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(N_FUNC); j++) begin
                mem_q[j] <= mem_d[j];
            end
        end
    end

    // Row read across all functions.
    always_comb begin
        for (int j = 0; j < int'(N_FUNC); j++) begin
            rd_f_o[j] = mem_q[j][rd_row_i];
        end
    end

endmodule

// File: rtl/lut_sweep_engine.sv
// Programmable multi-output LUT that streams results for one row (eval) or
// for every row in order (sweep) over a valid/ready output channel.
module lut_sweep_engine
    import lut_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = DefNIn,
    parameter int unsigned N_FUNC = DefNFunc,
    localparam int unsigned FuncW = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [FuncW-1:0]     cfg_func,
    input  logic [2**N_IN-1:0]   cfg_data,
    input  logic                 start,
    input  logic                 eval_en,
    input  logic [N_IN-1:0]      eval_in,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_IN-1:0]      out_row,
    output logic [N_FUNC-1:0]    out_f,
    output logic                 out_last,
    output logic                 busy
);

    state_e          state_q, state_d;
    logic [N_IN-1:0] row_q, row_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            hs;

    assign hs = valid_q & out_ready;

    // Next-state: abort beats handshake, start beats eval, and the row
    // counter stops at the last row instead of wrapping.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSweep;
                    row_d   = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end else if (eval_en) begin
                    state_d = StEval;
                    row_d   = eval_in;
                    valid_d = 1'b1;
                    last_d  = 1'b1;
                end
            end
            StEval: begin
                if (abort || hs) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            StSweep: begin
                if (abort || (hs && last_q)) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (hs) begin
                    row_d  = row_q + 1'b1;
                    last_d = &row_d;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_row   = row_q;
    assign out_last  = last_q;
    assign busy      = (state_q != StIdle);

    // Table is frozen whenever a sweep or eval is in flight.
    lut_sweep_table #(
        .N_IN   (N_IN),
        .N_FUNC (N_FUNC)
    ) u_table (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (cfg_we && (state_q == StIdle)),
        .wr_func_i (cfg_func),
        .wr_data_i (cfg_data),
        .rd_row_i  (row_q),
        .rd_f_o    (out_f)
    );

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Self-checking bench: queue-of-beats reference model plus directed literals.
module tb_lut_sweep_engine;

    localparam int NI   = 4;
    localparam int NF   = 10;
    localparam int ROWS = 16;
    localparam int FW   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance (defaults)
    logic          cfg_we, start, eval_en, abort, out_ready;
    logic [FW-1:0] cfg_func;
    logic [15:0]   cfg_data;
    logic [NI-1:0] eval_in;
    logic          out_valid, out_last, busy;
    logic [NI-1:0] out_row;
    logic [NF-1:0] out_f;

    lut_sweep_engine u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_func  (cfg_func),
        .cfg_data  (cfg_data),
        .start     (start),
        .eval_en   (eval_en),
        .eval_in   (eval_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_f     (out_f),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Small instance: 3 inputs, 2 functions
    logic       b_cfg_we, b_start, b_eval_en, b_abort, b_out_ready;
    logic [0:0] b_cfg_func;
    logic [7:0] b_cfg_data;
    logic [2:0] b_eval_in;
    logic       b_out_valid, b_out_last, b_busy;
    logic [2:0] b_out_row;
    logic [1:0] b_out_f;

    lut_sweep_engine #(
        .N_IN   (3),
        .N_FUNC (2)
    ) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (b_cfg_we),
        .cfg_func  (b_cfg_func),
        .cfg_data  (b_cfg_data),
        .start     (b_start),
        .eval_en   (b_eval_en),
        .eval_in   (b_eval_in),
        .abort     (b_abort),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_row   (b_out_row),
        .out_f     (b_out_f),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table contents plus the queue of beats still to deliver.
    logic [15:0] m_tbl [NF];
    int          m_q[$];
    logic [NF-1:0] m_f;
    logic        cmp_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NF; j++) m_tbl[j] = '0;
            m_q.delete();
        end else if (m_q.size() == 0) begin
            if (cfg_we && int'(cfg_func) < NF) m_tbl[cfg_func] = cfg_data;
            if (start) begin
                for (int r = 0; r < ROWS; r++) m_q.push_back(r);
            end else if (eval_en) begin
                m_q.push_back(int'(eval_in));
            end
        end else if (abort) begin
            m_q.delete();
        end else if (out_ready) begin
            void'(m_q.pop_front());
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("m_busy", 32'(busy), 32'(m_q.size() != 0));
            chk("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
            chk("m_last", 32'(out_last), 32'(m_q.size() == 1));
            if (m_q.size() != 0) begin
                for (int j = 0; j < NF; j++) m_f[j] = m_tbl[j][m_q[0]];
                chk("m_row", 32'(out_row), 32'(m_q[0]));
                chk("m_f", 32'(out_f), 32'(m_f));
            end
        end
    end

    task automatic cfg(input int f, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_func = FW'(f);
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_row(input int target, input int bound);
        int n = 0;
        while (int'(out_row) != target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("wait_row", 32'(out_row), 32'(target));
    endtask

    initial begin
        cfg_we = 0; cfg_func = '0; cfg_data = '0; start = 0; eval_en = 0;
        eval_in = '0; abort = 0; out_ready = 0;
        b_cfg_we = 0; b_cfg_func = '0; b_cfg_data = '0; b_start = 0; b_eval_en = 0;
        b_eval_in = '0; b_abort = 0; b_out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_row", 32'(out_row), 32'd0);
        chk("rst_f", 32'(out_f), 32'd0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // f4 = y&z: full sweep at one beat per cycle
        cfg(4, 16'h8888);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            chk("sw_valid", 32'(out_valid), 32'd1);
            chk("sw_row", 32'(out_row), 32'(r));
            chk("sw_f4", 32'(out_f[4]), 32'(r % 4 == 3));
            chk("sw_last", 32'(out_last), 32'(r == 15));
            @(negedge clk);
        end
        chk("sw_end_busy", 32'(busy), 32'd0);

        // Backpressure on row 5, with a write attempt while busy
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_row(5, 20);
        out_ready = 1'b0;
        cfg_we = 1'b1; cfg_func = 4'd4; cfg_data = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_row", 32'(out_row), 32'd5);
            chk("hold_valid", 32'(out_valid), 32'd1);
        end
        cfg_we = 1'b0;
        out_ready = 1'b1;
        for (int r = 6; r < ROWS; r++) begin
            @(negedge clk);
            chk("bp_row", 32'(out_row), 32'(r));
            chk("bp_f4", 32'(out_f[4]), 32'(r % 4 == 3));
        end
        @(negedge clk);
        chk("bp_end_busy", 32'(busy), 32'd0);

        // start + eval_en together: sweep wins; then abort beats handshake
        start = 1'b1; eval_en = 1'b1; eval_in = 4'd9;
        @(negedge clk);
        start = 1'b0; eval_en = 1'b0;
        chk("both_row", 32'(out_row), 32'd0);
        chk("both_last", 32'(out_last), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);

        // f5 = y'z' + w'x': single evaluations
        cfg(5, 16'h111F);
        out_ready = 1'b0;
        eval_en = 1'b1; eval_in = 4'b1011;
        @(negedge clk);
        eval_en = 1'b0;
        chk("ev_valid", 32'(out_valid), 32'd1);
        chk("ev_row", 32'(out_row), 32'd11);
        chk("ev_f5", 32'(out_f[5]), 32'd0);
        chk("ev_last", 32'(out_last), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ev_done", 32'(out_valid), 32'd0);
        eval_en = 1'b1; eval_in = 4'b0010;
        @(negedge clk);
        eval_en = 1'b0;
        chk("ev2_f5", 32'(out_f[5]), 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-sweep
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_row(7, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_row", 32'(out_row), 32'd0);
        chk("arst_f", 32'(out_f), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            chk("clr_f", 32'(out_f), 32'd0);
            @(negedge clk);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cfg_we    = ($urandom_range(0, 3) == 0);
            cfg_func  = FW'($urandom_range(0, 15));
            cfg_data  = 16'($urandom);
            start     = ($urandom_range(0, 19) == 0);
            eval_en   = ($urandom_range(0, 11) == 0);
            eval_in   = NI'($urandom);
            abort     = ($urandom_range(0, 31) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        cfg_we = 0; start = 0; eval_en = 0; abort = 0; out_ready = 0;
        @(negedge clk);

        // Small instance: majority function, then abort at row 4
        b_cfg_we = 1'b1; b_cfg_func = 1'b1; b_cfg_data = 8'hE8;
        @(negedge clk);
        b_cfg_we = 1'b0;
        b_out_ready = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int r = 0; r < 8; r++) begin
            chk("maj_row", 32'(b_out_row), 32'(r));
            chk("maj_f1", 32'(b_out_f[1]), 32'(r == 3 || r == 5 || r == 6 || r == 7));
            chk("maj_last", 32'(b_out_last), 32'(r == 7));
            @(negedge clk);
        end
        chk("maj_end_busy", 32'(b_busy), 32'd0);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int n = 0; n < 12 && b_out_row != 3'd4; n++) @(negedge clk);
        chk("maj_at4", 32'(b_out_row), 32'd4);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        chk("maj_abort_valid", 32'(b_out_valid), 32'd0);
        chk("maj_abort_busy", 32'(b_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
